step_sequencer_param: RTL and testbench

//  Parametrised N-step output sequencer; successor to the fixed 5-state restart/pause/goto sequencer.

---
 rtl/step_seq_pkg.sv | 27 ++
 rtl/step_seq_table.sv | 26 ++
 rtl/step_sequencer_param.sv | 150 +++++++++++++++
 tb/tb_step_sequencer_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/step_seq_pkg.sv
// Shared types for the parametrised step sequencer: run modes, ping-pong direction
// and the decode of the raw 2-bit mode input.
package step_seq_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_WRAP     = 2'b01,
        MODE_PINGPONG = 2'b10
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    // Encoding 2'b11 behaves as one-shot.
    function automatic mode_e decode_mode(input logic [MODE_W-1:0] raw);
        case (raw)
            2'b01:   return MODE_WRAP;
            2'b10:   return MODE_PINGPONG;
            default: return MODE_ONESHOT;
        endcase
    endfunction

endpackage

// File: rtl/step_seq_table.sv
// Combinational step index -> (out1, out2) lookup. Tables are packed MSB-first:
// the leftmost W-bit field of each table is the entry for step 0.
module step_seq_table #(
    parameter int unsigned W       = 3,
    parameter int unsigned N_STEPS = 5,
    parameter int unsigned IW      = 3,
    parameter logic [N_STEPS*W-1:0] OUT1_TBL = '0,
    parameter logic [N_STEPS*W-1:0] OUT2_TBL = '0
) (
    input  logic [IW-1:0] idx,
    output logic [W-1:0]  out1_c,
    output logic [W-1:0]  out2_c
);

    logic [W-1:0] tbl1 [N_STEPS];
    logic [W-1:0] tbl2 [N_STEPS];

    for (genvar i = 0; i < N_STEPS; i++) begin : g_tbl
        assign tbl1[i] = OUT1_TBL[(N_STEPS-1-i)*W +: W];
        assign tbl2[i] = OUT2_TBL[(N_STEPS-1-i)*W +: W];
    end

    assign out1_c = tbl1[idx];
    assign out2_c = tbl2[idx];

endmodule

// File: rtl/step_sequencer_param.sv
// Parametrised N-step output sequencer with goto, pause, one-shot/wrap/ping-pong
// modes and a saturating pass counter. State is {step_idx, dir} plus a one-shot done flag.
module step_sequencer_param
    import step_seq_pkg::*;
#(
    parameter int unsigned W       = 3,
    parameter int unsigned N_STEPS = 5,
    parameter int unsigned IW      = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
    parameter logic [N_STEPS*W-1:0] OUT1_TBL = {3'd3, 3'd5, 3'd2, 3'd6, 3'd1},
    parameter logic [N_STEPS*W-1:0] OUT2_TBL = {3'd2, 3'd4, 3'd7, 3'd1, 3'd5},
    parameter int unsigned CW      = 8
) (
    input  logic          clk,
    input  logic          restart,
    input  logic          pause,
    input  logic          goto_en,
    input  logic [IW-1:0] goto_idx,
    input  logic [1:0]    mode,
    output logic [W-1:0]  out1,
    output logic [W-1:0]  out2,
    output logic [IW-1:0] step_idx,
    output logic          odd,
    output logic          even,
    output logic          terminal,
    output logic          goto_err,
    output logic [CW-1:0] pass_cnt
);

    localparam logic [IW-1:0] LAST     = IW'(N_STEPS - 1);
    localparam logic [IW:0]   N_EXT    = (IW+1)'(N_STEPS);
    localparam logic [W-1:0]  OUT1_RST = OUT1_TBL[N_STEPS*W-1 -: W];
    localparam logic [W-1:0]  OUT2_RST = OUT2_TBL[N_STEPS*W-1 -: W];

    dir_e          dir, dir_nxt;
    mode_e         mode_q, mode_cur;
    logic          done, done_nxt;
    logic [IW-1:0] step_nxt;
    logic [CW-1:0] pass_nxt;
    logic          goto_err_nxt;
    logic          goto_ok;
    logic          pass_inc;
    logic [W-1:0]  out1_nxt_c;
    logic [W-1:0]  out2_nxt_c;

    step_seq_table #(
        .W        (W),
        .N_STEPS  (N_STEPS),
        .IW       (IW),
        .OUT1_TBL (OUT1_TBL),
        .OUT2_TBL (OUT2_TBL)
    ) u_table (
        .idx    (step_nxt),
        .out1_c (out1_nxt_c),
        .out2_c (out2_nxt_c)
    );

    // Next-step, direction, done and pass-count decision.
    always_comb begin
        mode_cur     = decode_mode(mode);
        step_nxt     = step_idx;
        dir_nxt      = (mode_q == MODE_PINGPONG && mode_cur != MODE_PINGPONG) ? UP : dir;
        done_nxt     = done && (mode_cur == mode_q);
        pass_nxt     = pass_cnt;
        goto_err_nxt = 1'b0;
        pass_inc     = 1'b0;
        goto_ok      = goto_en && ({1'b0, goto_idx} < N_EXT);

        if (goto_ok) begin
            step_nxt = goto_idx;
            dir_nxt  = UP;
            done_nxt = 1'b0;
        end else begin
            goto_err_nxt = goto_en;
            if (!pause) begin
                case (mode_cur)
                    MODE_WRAP: begin
                        if (step_idx == LAST) begin
                            step_nxt = '0;
                            pass_inc = 1'b1;
                        end else begin
                            step_nxt = step_idx + 1'b1;
                        end
                    end
                    MODE_PINGPONG: begin
                        if (N_STEPS == 1) begin
                            step_nxt = '0;
                        end else if (dir_nxt == UP) begin
                            if (step_idx == LAST) begin
                                dir_nxt  = DOWN;
                                step_nxt = step_idx - 1'b1;
                            end else begin
                                step_nxt = step_idx + 1'b1;
                            end
                        end else begin
                            if (step_idx == '0) begin
                                dir_nxt  = UP;
                                step_nxt = step_idx + 1'b1;
                            end else begin
                                step_nxt = step_idx - 1'b1;
                            end
                        end
                        pass_inc = (step_nxt == '0);
                    end
                    default: begin
                        if (!done_nxt && step_idx != LAST) begin
                            step_nxt = step_idx + 1'b1;
                            if (step_nxt == LAST) begin
                                pass_inc = 1'b1;
                                done_nxt = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end

        if (pass_inc && pass_cnt != '1) begin
            pass_nxt = pass_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            step_idx <= '0;
            dir      <= UP;
            done     <= 1'b0;
            mode_q   <= MODE_ONESHOT;
            pass_cnt <= '0;
            goto_err <= 1'b0;
            out1     <= OUT1_RST;
            out2     <= OUT2_RST;
            odd      <= 1'b1;
            even     <= 1'b0;
            terminal <= (N_STEPS == 1);
        end else begin
            step_idx <= step_nxt;
            dir      <= dir_nxt;
            done     <= done_nxt;
            mode_q   <= mode_cur;
            pass_cnt <= pass_nxt;
            goto_err <= goto_err_nxt;
            out1     <= out1_nxt_c;
            out2     <= out2_nxt_c;
            odd      <= ~step_nxt[0];
            even     <= step_nxt[0];
            terminal <= (step_nxt == LAST);
        end
    end

endmodule

// File: tb/tb_step_sequencer_param.sv
// Directed bench for step_sequencer_param: default 5-step instance plus a CW=2
// instance sharing the same stimulus for pass-counter saturation.
module tb_step_sequencer_param;

    logic       clk = 1'b0;
    logic       restart = 1'b1;
    logic       pause = 1'b0;
    logic       goto_en = 1'b0;
    logic [2:0] goto_idx = '0;
    logic [1:0] mode = 2'b01;

    logic [2:0] out1, out2, step_idx;
    logic       odd, even, terminal, goto_err;
    logic [7:0] pass_cnt;

    logic [2:0] s_out1, s_out2, s_step_idx;
    logic       s_odd, s_even, s_terminal, s_goto_err;
    logic [1:0] s_pass_cnt;

    int checks = 0;
    int errors = 0;

    int exp_o1 [5] = '{3, 5, 2, 6, 1};
    int exp_o2 [5] = '{2, 4, 7, 1, 5};

    always #5 clk = ~clk;

    step_sequencer_param dut (
        .clk      (clk),
        .restart  (restart),
        .pause    (pause),
        .goto_en  (goto_en),
        .goto_idx (goto_idx),
        .mode     (mode),
        .out1     (out1),
        .out2     (out2),
        .step_idx (step_idx),
        .odd      (odd),
        .even     (even),
        .terminal (terminal),
        .goto_err (goto_err),
        .pass_cnt (pass_cnt)
    );

    step_sequencer_param #(.CW(2)) dut_sat (
        .clk      (clk),
        .restart  (restart),
        .pause    (pause),
        .goto_en  (goto_en),
        .goto_idx (goto_idx),
        .mode     (mode),
        .out1     (s_out1),
        .out2     (s_out2),
        .step_idx (s_step_idx),
        .odd      (s_odd),
        .even     (s_even),
        .terminal (s_terminal),
        .goto_err (s_goto_err),
        .pass_cnt (s_pass_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_step(input string tag, input int s);
        check({tag, ".step"}, int'(step_idx), s);
        check({tag, ".out1"}, int'(out1), exp_o1[s]);
        check({tag, ".out2"}, int'(out2), exp_o2[s]);
        check({tag, ".odd"},  int'(odd),  (s % 2 == 0) ? 1 : 0);
        check({tag, ".even"}, int'(even), (s % 2 == 0) ? 0 : 1);
        check({tag, ".term"}, int'(terminal), (s == 4) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart(input logic [1:0] m);
        restart = 1'b1;
        mode    = m;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        int wrap_seq [5] = '{1, 2, 3, 4, 0};
        int wrap_pc  [5] = '{0, 0, 0, 0, 1};
        int os_seq   [8] = '{1, 2, 3, 4, 4, 4, 4, 4};
        int pp_seq   [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
        int pp_pc    [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

        // reset state
        do_restart(2'b01);
        check_step("rst", 0);
        check("rst.goto_err", int'(goto_err), 0);
        check("rst.pass", int'(pass_cnt), 0);
        check("rst.sat_pass", int'(s_pass_cnt), 0);

        // wrap
        for (int i = 0; i < 5; i++) begin
            tick();
            check_step($sformatf("wrap%0d", i), wrap_seq[i]);
            check($sformatf("wrap%0d.pass", i), int'(pass_cnt), wrap_pc[i]);
        end

        // one-shot
        do_restart(2'b00);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_step($sformatf("os%0d", i), os_seq[i]);
        end
        check("os.pass", int'(pass_cnt), 1);
        mode = 2'b01;
        tick();
        check_step("os2wrap", 0);
        check("os2wrap.pass", int'(pass_cnt), 2);

        // ping-pong
        do_restart(2'b10);
        for (int i = 0; i < 9; i++) begin
            tick();
            check_step($sformatf("pp%0d", i), pp_seq[i]);
            check($sformatf("pp%0d.pass", i), int'(pass_cnt), pp_pc[i]);
        end

        // pause, then goto overriding pause
        do_restart(2'b01);
        tick();
        tick();
        check_step("pre_pause", 2);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_step($sformatf("pause%0d", i), 2);
        end
        goto_en  = 1'b1;
        goto_idx = 3'd4;
        tick();
        check_step("goto4", 4);
        check("goto4.err", int'(goto_err), 0);
        check("goto4.pass", int'(pass_cnt), 0);
        goto_en = 1'b0;
        pause   = 1'b0;
        tick();
        check_step("after_goto", 0);
        check("after_goto.pass", int'(pass_cnt), 1);

        // invalid goto
        goto_en  = 1'b1;
        goto_idx = 3'd7;
        tick();
        check("bad7.err", int'(goto_err), 1);
        check_step("bad7", 1);
        goto_en = 1'b0;
        tick();
        check("bad7_next.err", int'(goto_err), 0);
        check_step("bad7_next", 2);
        goto_en  = 1'b1;
        goto_idx = 3'd5;
        pause    = 1'b1;
        tick();
        check("bad5p.err", int'(goto_err), 1);
        check_step("bad5p", 2);
        goto_en = 1'b0;
        pause   = 1'b0;
        tick();
        check("bad5p_next.err", int'(goto_err), 0);
        check_step("bad5p_next", 3);

        // restart during ping-pong descent
        do_restart(2'b10);
        for (int i = 0; i < 13; i++) tick();
        check_step("pp_desc", 3);
        check("pp_desc.pass", int'(pass_cnt), 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_step("pp_rst", 0);
        check("pp_rst.pass", int'(pass_cnt), 0);
        tick();
        check_step("pp_rst_up", 1);

        // saturation on the CW=2 instance
        do_restart(2'b01);
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i % 5 == 0) begin
                check($sformatf("sat%0d.pass", i), int'(pass_cnt), i / 5);
                check($sformatf("sat%0d.s_pass", i), int'(s_pass_cnt), (i / 5 > 3) ? 3 : i / 5);
            end
        end
        check("sat.s_step", int'(s_step_idx), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
